column_readout_arbiter: RTL and testbench
=========================================

# column_readout_arbiter

Parametrised column readout block that collects hit packets from N_SP daisy-positioned super pixels in one double column and delivers them, tagged with super-pixel address, to the column periphery over a valid/ready handshake. It generalises the two-super-pixel column:
- arbitration is centralised instead of chained;
- the super-pixel count is a parameter;
- a small output FIFO decouples pixel grant from periphery backpressure;
- delivered packets are counted.

It sits between the per-super-pixel arbiter outputs and the column-level serialiser, in the clk_40MHz domain.

## Interface
Parameters:
- N_SP, 2, super pixels per column (2..16)
- DATA_W, 25, payload bits per super-pixel packet
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)
- ADDR_W, $clog2(N_SP), derived; not overridden

Ports:
- clk_40MHz  in  1  readout clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear: empties FIFO, resets arbiter pointer and counter
- sp_valid  in  N_SP  super pixel i holds a packet
- sp_data  in  N_SP*DATA_W  packet of super pixel i at bits [i*DATA_W +: DATA_W]
- sp_ack  out  N_SP  one-hot, packet of super pixel i taken at this edge
- col_valid  out  1  FIFO head valid
- col_ready  in  1  periphery accepts (shake_hands_col)
- col_data  out  ADDR_W+DATA_W  {sp_addr, payload}
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- pkt_cnt  out  16  packets delivered, saturating

## Operation
- Request vector: req = sp_valid, gated to zero when clr=1.
- Push condition: push = |req && (!full || pop), where pop = col_valid && col_ready.
  - Push into a full FIFO is allowed only in the same cycle as a pop.
- Grant:
  - exactly one index g when push;
  - sp_ack[g] = 1, combinational from registered state and sp_valid; zero otherwise;
  - {g, sp_data[g]} is written at the same edge.
- Super-pixel contract:
  - sp_data is held stable while sp_valid is high;
  - a slot that sees sp_ack must present its next packet, or drop sp_valid, by the following cycle;
  - sp_valid high in the cycle after an ack is a new packet.
- Default arbitration is fixed priority, lowest index wins (index 0 = bottom super pixel).
- pkt_cnt increments on every pop and saturates at 16'hFFFF.
- clr=1:
  - next edge sets FIFO empty, arbiter pointer 0, pkt_cnt 0;
  - no ack in that cycle;
  - a pop in that cycle is not counted.
- Reset values: sp_ack=0, col_valid=0, col_data=0, fifo_level=0, pkt_cnt=0, RR pointer=0.
  - Reset mid-transfer discards all FIFO contents; no partial packet is emitted.

## Timing
- Latency: with the FIFO empty, a packet acked at edge k drives col_data with col_valid=1 from edge k (visible in cycle k+1).
- Throughput: one packet per cycle in and out sustained.
- col_data is stable while col_valid=1 and col_ready=0.
- Full and no pop: all sp_ack=0; sp_valid held by slots, no loss.
- Empty: col_valid=0 and col_data holds its last value (0 after reset).
- Pointer wrap: after grant to index N_SP-1, the RR pointer returns to 0.
- fifo_level counts 0..FIFO_DEPTH inclusive; simultaneous push and pop leaves it unchanged.

## Configuration
- COL_RR_ARB_EN defined: round-robin arbitration.
  - Search starts at pointer p; pointer := g+1 mod N_SP after each grant.
  - Guarantees each requesting slot is granted within N_SP grants.
- Undefined: fixed lowest-index priority; pointer logic absent.

## Structure
- Package col_ro_pkg holds:
  - default DATA_W and N_SP;
  - packet struct typedef {addr, payload};
  - PKT_CNT_W=16.
- Sub-module col_ro_fifo: synchronous FIFO with async active-low reset, clr, level output and push-on-full-with-pop support.
- Arbiter stays inline.

## Test plan
- N_SP=4, single sp_valid[2] with payload 25'h0ABCDE, col_ready=1 → sp_ack[2] for one cycle; next cycle col_valid=1, col_data={2'd2,25'h0ABCDE}; pkt_cnt=1.
- All four slots valid, fixed priority, col_ready=1 → acks in order 0,1,2,3 on consecutive cycles; col_data addrs 0,1,2,3.
- Same stimulus with COL_RR_ARB_EN, slots held continuously valid → grants 0,1,2,3,0,1 on consecutive cycles; no slot starved.
- col_ready=0, slot 0 valid continuously with FIFO_DEPTH=4 → 4 acks; fifo_level=4; no further ack. Raise col_ready → one ack per cycle with one pop per cycle; level stays 4.
- FIFO holds 3 entries, assert clr for one cycle with sp_valid=1 → no ack that cycle; next cycle fifo_level=0, col_valid=0, pkt_cnt=0.
- Pulse rst_n low while col_valid=1 → all outputs 0 immediately (async); after release the first packet out is a newly acked one.

Source files
------------

// File: rtl/col_ro_pkg.sv
// Shared defaults and packet layout for the column readout arbiter.
// Optional round-robin arbitration is selected with COL_RR_ARB_EN.
package col_ro_pkg;

  localparam int DEF_N_SP   = 2;
  localparam int DEF_DATA_W = 25;
  localparam int PKT_CNT_W  = 16;
  localparam int MAX_ADDR_W = 4;

  // Packet layout at default payload width; addr sized for the largest column.
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] payload;
  } col_pkt_t;

endpackage

// File: rtl/col_ro_fifo.sv
// Synchronous FIFO with level output; a push into a full FIFO is accepted when a pop happens at the same edge.
// When empty, head_data keeps showing the last head value (0 after reset).
module col_ro_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [WIDTH-1:0] hold_q;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (level != '0);
  assign full       = (level == LVL_W'(DEPTH));
  assign do_pop     = pop && head_valid && !clr;
  assign do_push    = push && (!full || do_pop) && !clr;
  assign head_data  = head_valid ? mem[rd_ptr] : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      hold_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (head_valid) begin
        hold_q <= mem[rd_ptr];
      end
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/column_readout_arbiter.sv
// Arbitrates N_SP super-pixel packets into an output FIFO tagged with super-pixel address; counts delivered packets.
// Fixed lowest-index priority by default, round-robin when COL_RR_ARB_EN is defined.
module column_readout_arbiter
  import col_ro_pkg::*;
#(
  parameter  int N_SP       = DEF_N_SP,
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_W     = $clog2(N_SP),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk_40MHz,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [N_SP-1:0]          sp_valid,
  input  logic [N_SP*DATA_W-1:0]   sp_data,
  output logic [N_SP-1:0]          sp_ack,
  output logic                     col_valid,
  input  logic                     col_ready,
  output logic [ADDR_W+DATA_W-1:0] col_data,
  output logic [LVL_W-1:0]         fifo_level,
  output logic [PKT_CNT_W-1:0]     pkt_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] payload;
  } pkt_t;

  logic [N_SP-1:0]   req;
  logic [DATA_W-1:0] slot_data [N_SP];
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic [ADDR_W-1:0] gnt_idx;
  logic              gnt_found;
  pkt_t              wr_pkt;

  for (genvar i = 0; i < N_SP; i++) begin : g_unpack
    assign slot_data[i] = sp_data[i*DATA_W +: DATA_W];
  end

  // Requests are masked during clear and while reset is asserted so no ack escapes.
  assign req  = (clr || !rst_n) ? '0 : sp_valid;
  assign pop  = col_valid && col_ready;
  assign push = gnt_found && (!fifo_full || pop);

`ifdef COL_RR_ARB_EN
  logic [ADDR_W-1:0] rr_ptr;
  logic [ADDR_W:0]   cand;

  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_SP; k++) begin
      cand = {1'b0, rr_ptr} + (ADDR_W+1)'(k);
      if (cand >= (ADDR_W+1)'(N_SP)) begin
        cand = cand - (ADDR_W+1)'(N_SP);
      end
      if (!gnt_found && req[cand[ADDR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (clr) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gnt_idx == ADDR_W'(N_SP-1)) ? '0 : gnt_idx + ADDR_W'(1);
    end
  end
`else
  // Scan downward so the lowest requesting index is the last one written.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = N_SP-1; k >= 0; k--) begin
      if (req[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = ADDR_W'(k);
      end
    end
  end
`endif

  always_comb begin
    sp_ack = '0;
    if (push) begin
      sp_ack[gnt_idx] = 1'b1;
    end
  end

  assign wr_pkt = '{addr: gnt_idx, payload: slot_data[gnt_idx]};

  col_ro_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_40MHz),
    .rst_n      (rst_n),
    .clr        (clr),
    .push       (push),
    .push_data  (wr_pkt),
    .pop        (pop),
    .head_data  (col_data),
    .head_valid (col_valid),
    .full       (fifo_full),
    .level      (fifo_level)
  );

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (clr) begin
      pkt_cnt <= '0;
    end else if (pop && (pkt_cnt != '1)) begin
      pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_column_readout_arbiter.sv
// Randomised bench for column_readout_arbiter: queue-based reference model feeds a scoreboard checked by a monitor.
module tb_column_readout_arbiter;
  import col_ro_pkg::*;

  localparam int N_SP       = 4;
  localparam int DATA_W     = 25;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 2;
  localparam int LVL_W      = 3;
  localparam int PW         = ADDR_W + DATA_W;

  logic                   clk_40MHz = 1'b0;
  logic                   rst_n     = 1'b0;
  logic                   clr       = 1'b0;
  logic                   col_ready = 1'b0;
  logic [N_SP-1:0]        sp_valid  = '0;
  logic [N_SP*DATA_W-1:0] sp_data   = '0;
  logic [N_SP-1:0]        sp_ack;
  logic                   col_valid;
  logic [PW-1:0]          col_data;
  logic [LVL_W-1:0]       fifo_level;
  logic [PKT_CNT_W-1:0]   pkt_cnt;

  int checks   = 0;
  int failures = 0;

  column_readout_arbiter #(
    .N_SP       (N_SP),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_40MHz  (clk_40MHz),
    .rst_n      (rst_n),
    .clr        (clr),
    .sp_valid   (sp_valid),
    .sp_data    (sp_data),
    .sp_ack     (sp_ack),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .col_data   (col_data),
    .fifo_level (fifo_level),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 clk_40MHz = ~clk_40MHz;

  // Reference state: expected FIFO contents, occupancy, delivered count, search start.
  logic [PW-1:0]     exp_q[$];
  int                m_lvl = 0;
  int                m_cnt = 0;
  int                m_ptr = 0;
  logic [N_SP-1:0]   v        = '0;
  logic [N_SP-1:0]   last_ack = '0;
  logic [N_SP-1:0]   en_mask  = '0;
  logic [DATA_W-1:0] d [N_SP];
  int                gen_prob = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N_SP-1:0] r, input int p);
    for (int k = 0; k < N_SP; k++) begin
      if (r[(p + k) % N_SP]) return (p + k) % N_SP;
    end
    return -1;
  endfunction

  task automatic cycle(input bit rdy, input bit c, input bit do_rst);
    logic [N_SP-1:0] exp_ack;
    bit              pop_m;
    bit              full_m;
    int              g;
    @(negedge clk_40MHz);
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      check("rst_sp_ack", 64'(sp_ack), 64'd0);
      check("rst_col_valid", 64'(col_valid), 64'd0);
      check("rst_col_data", 64'(col_data), 64'd0);
      check("rst_fifo_level", 64'(fifo_level), 64'd0);
      check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      rst_n = 1'b1;
      exp_q.delete();
      m_lvl = 0;
      m_cnt = 0;
      m_ptr = 0;
    end
    // Slot behaviour: an acked slot offers a fresh packet or goes idle; idle slots may raise a packet.
    for (int i = 0; i < N_SP; i++) begin
      if (last_ack[i] || !v[i]) begin
        if (en_mask[i] && ($urandom_range(0, 99) < gen_prob)) begin
          v[i] = 1'b1;
          d[i] = DATA_W'($urandom());
        end else begin
          v[i] = 1'b0;
        end
      end
    end
    sp_valid = v;
    for (int i = 0; i < N_SP; i++) sp_data[i*DATA_W +: DATA_W] = d[i];
    col_ready = rdy;
    clr       = c;
    #1;
    check("col_valid", 64'(col_valid), 64'(m_lvl > 0));
    check("fifo_level", 64'(fifo_level), 64'(m_lvl));
    check("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
    exp_ack = '0;
    pop_m   = (m_lvl > 0) && rdy;
    full_m  = (m_lvl == FIFO_DEPTH);
    if (c) begin
      exp_q.delete();
      m_lvl = 0;
      m_cnt = 0;
      m_ptr = 0;
    end else begin
      if (pop_m) begin
        m_lvl--;
        if (m_cnt < 65535) m_cnt++;
      end
      if ((v != '0) && (!full_m || pop_m)) begin
        g = pick(v, m_ptr);
        exp_ack[g] = 1'b1;
        exp_q.push_back({ADDR_W'(g), d[g]});
        m_lvl++;
`ifdef COL_RR_ARB_EN
        m_ptr = (g + 1) % N_SP;
`endif
      end
    end
    check("sp_ack", 64'(sp_ack), 64'(exp_ack));
    last_ack = exp_ack;
  endtask

  // Monitor: every accepted handshake must deliver the oldest expected packet.
  initial begin
    logic [PW-1:0] exp_pkt;
    forever begin
      @(negedge clk_40MHz);
      #3;
      if (rst_n && !clr && col_valid && col_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL col_data_unexpected: got %0h expected no packet", col_data);
        end else begin
          exp_pkt = exp_q.pop_front();
          check("col_data", 64'(col_data), 64'(exp_pkt));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N_SP; i++) d[i] = '0;
    repeat (2) @(negedge clk_40MHz);
    rst_n = 1'b1;
    #1;
    check("reset_col_valid", 64'(col_valid), 64'd0);
    check("reset_col_data", 64'(col_data), 64'd0);
    check("reset_fifo_level", 64'(fifo_level), 64'd0);
    check("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("reset_sp_ack", 64'(sp_ack), 64'd0);

    // Single packet from slot 2.
    v[2] = 1'b1;
    d[2] = 25'h0ABCDE;
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    // All four slots raise one packet each.
    v = '1;
    for (int i = 0; i < N_SP; i++) d[i] = DATA_W'($urandom());
    repeat (6) cycle(1'b1, 1'b0, 1'b0);

    // All slots continuously valid, then drain.
    en_mask  = '1;
    gen_prob = 100;
    repeat (8) cycle(1'b1, 1'b0, 1'b0);
    en_mask = '0;
    repeat (8) cycle(1'b1, 1'b0, 1'b0);

    // Backpressure fills the FIFO, then sustained push-with-pop at full level.
    en_mask = 4'b0001;
    repeat (7) cycle(1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    en_mask = '0;
    repeat (8) cycle(1'b1, 1'b0, 1'b0);

    // Clear with three entries queued and a slot requesting.
    en_mask = 4'b0001;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    en_mask = '0;
    repeat (6) cycle(1'b1, 1'b0, 1'b0);

    // Reset while packets are waiting.
    en_mask = 4'b0011;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("pre_reset_col_valid", 64'(col_valid), 64'd1);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (6) cycle(1'b1, 1'b0, 1'b0);

    // Random traffic with random backpressure, occasional clear and reset.
    repeat (1500) begin
      en_mask  = N_SP'($urandom());
      gen_prob = $urandom_range(20, 100);
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 199) == 0, $urandom_range(0, 499) == 0);
    end

    en_mask = '0;
    repeat (20) cycle(1'b1, 1'b0, 1'b0);
    @(negedge clk_40MHz);
    #4;
    check("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("drain_col_valid", 64'(col_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
